// File: rtl/cic_decim_tdm.sv
// Multi-channel TDM CIC decimator, D = 2^k selected at runtime, gain-compensated and saturated.
// Build option: define CIC_ROUND_EN to round half up before the gain shift (default truncates).
module cic_decim_tdm #(
  parameter  int DATA_WIDTH   = 16,
  parameter  int NUM_STAGES   = 3,
  parameter  int MAX_LOG2_DEC = 4,
  parameter  int NUM_CH       = 2,
  localparam int W            = DATA_WIDTH + NUM_STAGES * MAX_LOG2_DEC,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cfg_load,
  input  logic [2:0]                   dec_log2,
  input  logic                         in_valid,
  input  logic [CH_W-1:0]              in_ch,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  output logic [CH_W-1:0]              out_ch,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  localparam logic [2:0]        K_MAX  = 3'(MAX_LOG2_DEC);
  localparam logic signed [W:0] SAT_HI = (W+1)'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [W:0] SAT_LO = ~SAT_HI;

  logic [W-1:0]            r_integ [NUM_CH][NUM_STAGES];
  logic [W-1:0]            r_cdly  [NUM_CH][NUM_STAGES];
  logic [MAX_LOG2_DEC-1:0] r_phase [NUM_CH];
  logic [2:0]              r_k;
  logic                    r_s2_vld;
  logic [CH_W-1:0]         r_s2_ch;
  logic [W-1:0]            r_s2_data;

  logic                    w_in_ok;
  logic [W-1:0]            w_in_ext;
  logic [W-1:0]            w_int_nxt [NUM_STAGES];
  logic [W-1:0]            w_comb [NUM_STAGES+1];
  logic [MAX_LOG2_DEC-1:0] w_dmask;
  logic [7:0]              w_shamt;
  logic [2:0]              w_k_req;
  logic signed [W:0]       w_pre;
  logic signed [W:0]       w_shr;
  logic [DATA_WIDTH-1:0]   w_sat;

  assign w_in_ok  = in_valid && (32'(in_ch) < NUM_CH);
  assign w_in_ext = {{(W - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign w_dmask  = (MAX_LOG2_DEC'(1) << r_k) - MAX_LOG2_DEC'(1);
  assign w_shamt  = 8'(r_k * NUM_STAGES);
  assign w_k_req  = (dec_log2 > K_MAX) ? K_MAX : dec_log2;

  // Integrator chain feeds each stage with the freshly updated value of the previous one.
  always_comb begin
    w_int_nxt[0] = r_integ[in_ch][0] + w_in_ext;
    for (int s = 1; s < NUM_STAGES; s++)
      w_int_nxt[s] = r_integ[in_ch][s] + w_int_nxt[s-1];
  end

  always_comb begin
    w_comb[0] = r_s2_data;
    for (int s = 0; s < NUM_STAGES; s++)
      w_comb[s+1] = w_comb[s] - r_cdly[r_s2_ch][s];
  end

  // One guard bit keeps the rounding offset from wrapping the comb result.
  always_comb begin
    w_pre = {w_comb[NUM_STAGES][W-1], w_comb[NUM_STAGES]};
`ifdef CIC_ROUND_EN
    if (w_shamt != 8'd0)
      w_pre = w_pre + ((W+1)'(1) << (w_shamt - 8'd1));
`endif
    w_shr = w_pre >>> w_shamt;
    if (w_shr > SAT_HI)
      w_sat = DATA_WIDTH'(SAT_HI);
    else if (w_shr < SAT_LO)
      w_sat = DATA_WIDTH'(SAT_LO);
    else
      w_sat = DATA_WIDTH'(w_shr);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_phase[c] <= '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
          r_integ[c][s] <= '0;
          r_cdly[c][s]  <= '0;
        end
      end
      r_k       <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_ch   <= '0;
      r_s2_data <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else if (cfg_load) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_phase[c] <= '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
          r_integ[c][s] <= '0;
          r_cdly[c][s]  <= '0;
        end
      end
      r_k       <= w_k_req;
      r_s2_vld  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_s2_vld;
      if (r_s2_vld) begin
        out_ch   <= r_s2_ch;
        out_data <= w_sat;
        for (int s = 0; s < NUM_STAGES; s++)
          r_cdly[r_s2_ch][s] <= w_comb[s];
      end
      r_s2_vld <= 1'b0;
      if (w_in_ok) begin
        for (int s = 0; s < NUM_STAGES; s++)
          r_integ[in_ch][s] <= w_int_nxt[s];
        if (r_phase[in_ch] == w_dmask) begin
          r_phase[in_ch] <= '0;
          r_s2_vld       <= 1'b1;
          r_s2_ch        <= in_ch;
          r_s2_data      <= w_int_nxt[NUM_STAGES-1];
        end else begin
          r_phase[in_ch] <= r_phase[in_ch] + MAX_LOG2_DEC'(1);
        end
      end
    end
  end

endmodule
